// File: rtl/gpio_monitor.sv
// Receive-side GPIO monitor: synchronises and debounces one asynchronous pin,
// emits rise/fall pulses and measures each high and low phase in clock cycles.
module gpio_monitor #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 27
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_gpio,
   input  logic             i_clear,
   output logic             o_level,
   output logic             o_rise,
   output logic             o_fall,
   output logic [CNT_W-1:0] o_high_cycles,
   output logic             o_high_valid,
   output logic [CNT_W-1:0] o_low_cycles,
   output logic             o_low_valid,
   output logic             o_overflow
);

   localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

   logic             s1, s2;
   logic [7:0]       db;
   logic [CNT_W-1:0] cnt;
   logic             armed;
   logic             toggle;

   // The debounced level flips on this edge when the new value has persisted long enough.
   assign toggle = (s2 != o_level) && (db == DB_LAST);

   // NOTE: reset is sampled inside the clocked block, so it is synchronous; every
   // state register, including the measurement outputs, is cleared by it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         db            <= '0;
         o_level       <= 1'b0;
         o_rise        <= 1'b0;
         o_fall        <= 1'b0;
         cnt           <= '0;
         armed         <= 1'b0;
         o_high_cycles <= '0;
         o_high_valid  <= 1'b0;
         o_low_cycles  <= '0;
         o_low_valid   <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make s2 take the old s1, giving a true two-flop chain.
         s1           <= i_gpio;
         s2           <= s1;
         o_rise       <= 1'b0;
         o_fall       <= 1'b0;
         o_high_valid <= 1'b0;
         o_low_valid  <= 1'b0;

         if (s2 == o_level) begin
            db <= '0;
         end else if (toggle) begin
            db      <= '0;
            o_level <= s2;
            o_rise  <= s2;
            o_fall  <= ~s2;
         end else begin
            db <= db + 1'b1;
         end

         if (i_clear) begin
            cnt           <= '0;
            armed         <= 1'b0;
            o_high_cycles <= '0;
            o_low_cycles  <= '0;
            o_overflow    <= 1'b0;
         end else if (toggle) begin
            // A phase is reported only if its start edge was seen.
            if (armed) begin
               if (s2) begin
                  o_low_cycles <= cnt;
                  o_low_valid  <= 1'b1;
               end else begin
                  o_high_cycles <= cnt;
                  o_high_valid  <= 1'b1;
               end
            end
            armed <= 1'b1;
            cnt   <= CNT_W'(1);
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRE) o_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gpio_monitor.sv
// Scoreboard bench for gpio_monitor: a timestamp-based reference model predicts
// every edge event and the steady outputs; a monitor compares on the falling edge.
module tb_gpio_monitor;

   localparam int DB  = 4;
   localparam int CW  = 8;
   localparam int MAX = (1 << CW) - 1;

   typedef struct packed {
      logic          rise;
      logic          fall;
      logic          hv;
      logic          lv;
      logic [CW-1:0] hi;
      logic [CW-1:0] lo;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          gpio = 1'b1;
   logic          clear = 1'b0;
   logic          o_level, o_rise, o_fall, o_high_valid, o_low_valid, o_overflow;
   logic [CW-1:0] o_high_cycles, o_low_cycles;

   int checks = 0;
   int failures = 0;
   int clr_pct = 0;
   int n_rise = 0;

   gpio_monitor #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_gpio(gpio), .i_clear(clear),
      .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
      .o_high_cycles(o_high_cycles), .o_high_valid(o_high_valid),
      .o_low_cycles(o_low_cycles), .o_low_valid(o_low_valid),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: edges are counted, a phase starts at a timestamp, and its
   // length is the elapsed edge count clipped at the counter maximum.
   int   e = 0;
   bit   m_s1, m_s2, m_lvl, m_armed, m_ovf, m_tr;
   int   m_run, m_origin, m_len;
   logic [CW-1:0] m_hi, m_lo;
   ev_t  m_ev;
   ev_t  q[$];

   always @(posedge clk) begin
      e++;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_armed = 0; m_ovf = 0;
         m_run = 0; m_origin = e; m_hi = '0; m_lo = '0;
      end else begin
         m_ev = '0;
         m_tr = 0;
         if (m_s2 == m_lvl) m_run = 0;
         else begin
            m_run++;
            if (m_run == DB) begin m_tr = 1; m_run = 0; end
         end
         m_len = e - 1 - m_origin;
         if (m_len > MAX) m_len = MAX;
         if (m_tr) begin
            m_lvl   = m_s2;
            m_ev.rise = m_lvl;
            m_ev.fall = !m_lvl;
            if (m_armed && !clear) begin
               if (m_lvl) begin m_lo = CW'(m_len); m_ev.lv = 1; end
               else       begin m_hi = CW'(m_len); m_ev.hv = 1; end
            end
            m_armed = !clear;
         end
         if (clear) begin
            m_hi = '0; m_lo = '0; m_ovf = 0; m_armed = 0; m_origin = e;
         end else if (m_tr) m_origin = e - 1;
         else if (e - m_origin >= MAX) m_ovf = 1;
         m_ev.hi = m_hi;
         m_ev.lo = m_lo;
         if (m_tr) q.push_back(m_ev);
         m_s2 = m_s1;
         m_s1 = gpio;
      end
   end

   // Monitor: pops an expected event whenever the DUT pulses, and checks steady outputs.
   always @(negedge clk) begin
      ev_t exp_ev;
      if (e > 0) begin
         if (o_rise) n_rise++;
         if (o_rise || o_fall || o_high_valid || o_low_valid) begin
            if (q.size() == 0) check("sb_unexpected_event", 32'd1, 32'd0);
            else begin
               exp_ev = q.pop_front();
               check("sb_event", 32'({o_rise, o_fall, o_high_valid, o_low_valid,
                                      o_high_cycles, o_low_cycles}), 32'(exp_ev));
            end
         end
         check("sb_missing_event", q.size(), 0);
         check("level", 32'(o_level), 32'(m_lvl));
         check("overflow", 32'(o_overflow), 32'(m_ovf));
         check("high_cycles", 32'(o_high_cycles), 32'(m_hi));
         check("low_cycles", 32'(o_low_cycles), 32'(m_lo));
      end
   end

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         gpio  = v;
         clear = (clr_pct > 0) && ($urandom_range(999) < clr_pct);
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      int rise_at, lv_seen, r0, len;
      bit lvl;

      // Reset held with the pin high: everything stays zero.
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", 32'({o_level, o_rise, o_fall, o_high_valid, o_low_valid,
                                     o_overflow, o_high_cycles, o_low_cycles}), 32'd0);
      end
      rst_n = 1'b1;
      rise_at = 0;
      lv_seen = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (o_rise && rise_at == 0) rise_at = k;
         if (o_low_valid) lv_seen = 1;
      end
      check("reset_first_rise_clock", rise_at, 6);
      check("reset_no_low_valid", lv_seen, 0);

      // Square wave of 101-cycle phases.
      for (int i = 0; i < 2; i++) begin
         drive(0, 101);
         drive(1, 101);
      end
      drive(0, 30);
      check("square_high", 32'(o_high_cycles), 32'd101);
      check("square_low", 32'(o_low_cycles), 32'd101);
      check("square_overflow", 32'(o_overflow), 32'd0);

      // Glitch rejection.
      r0 = n_rise;
      drive(1, 3);
      drive(0, 20);
      check("glitch3_no_rise", n_rise - r0, 0);
      check("glitch3_level", 32'(o_level), 32'd0);
      drive(1, 4);
      drive(0, 20);
      check("glitch4_one_rise", n_rise - r0, 1);

      // Clear in the middle of a 200-cycle high phase.
      drive(1, 50);
      pulse_clear();
      drive(1, 149);
      drive(0, 80);
      drive(1, 30);
      check("clear_high_unreported", 32'(o_high_cycles), 32'd0);
      check("clear_next_low", 32'(o_low_cycles), 32'd80);

      // Saturation of a 300-cycle high phase.
      drive(1, 300);
      check("ovf_set", 32'(o_overflow), 32'd1);
      drive(0, 40);
      check("ovf_high_saturated", 32'(o_high_cycles), 32'(MAX));
      check("ovf_sticky", 32'(o_overflow), 32'd1);
      pulse_clear();
      check("ovf_cleared", 32'(o_overflow), 32'd0);

      // Clear coincident with a fall.
      drive(1, 50);
      @(negedge clk);
      gpio = 1'b0;
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("simul_fall", 32'(o_fall), 32'd1);
      check("simul_no_high_valid", 32'(o_high_valid), 32'd0);
      check("simul_high_zero", 32'(o_high_cycles), 32'd0);
      drive(0, 20);
      drive(1, 30);
      check("simul_low_unreported", 32'(o_low_cycles), 32'd0);

      // Randomised phases with occasional clears and one mid-run reset.
      clr_pct = 3;
      lvl = 1'b0;
      for (int i = 0; i < 60; i++) begin
         len = ($urandom_range(3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(10, 300));
         drive(lvl, len);
         lvl = !lvl;
         if (i == 30) begin
            @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      end
      clr_pct = 0;
      drive(0, 40);
      check("final_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
